// File: rtl/spike_rate_encoder.sv
// Rate encoder: converts a vector of unsigned intensities into per-channel spike trains
// over NUM_STEPS timesteps, using a phase accumulator (MODE 0) or a Galois LFSR (MODE 1).
module spike_rate_encoder #(
  parameter int          NUM_CHANNELS = 4,
  parameter int          VALUE_WIDTH  = 8,
  parameter int          NUM_STEPS    = 16,
  parameter int          MODE         = 0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_CHANNELS*VALUE_WIDTH-1:0] in_data,
  input  logic                                step_en,
  input  logic                                abort,
  output logic [NUM_CHANNELS-1:0]             spike_out,
  output logic                                spike_valid,
  output logic                                neuron_clr,
  output logic                                busy,
  output logic                                done,
  output logic                                o_dbg_state
);

  // Handshake: a vector transfers on any rising edge where in_valid && in_ready.
  // in_ready is high exactly while IDLE; step_en and abort only act while RUN.

  localparam int          CW        = $clog2(NUM_STEPS + 1);
  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                  r_state;
  logic [VALUE_WIDTH-1:0]  r_value [NUM_CHANNELS];
  logic [VALUE_WIDTH:0]    r_acc   [NUM_CHANNELS];
  logic [15:0]             r_lfsr;
  logic [CW-1:0]           r_step_cnt;
  logic [NUM_CHANNELS-1:0] r_spike_out;
  logic                    r_spike_valid;
  logic                    r_neuron_clr;
  logic                    r_done;

  logic [NUM_CHANNELS-1:0] w_spike;
  logic [VALUE_WIDTH:0]    w_acc_next [NUM_CHANNELS];
  logic [15:0]             w_lfsr_next;
  logic [CW-1:0]           w_step_next;
  logic                    w_last;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    if (MODE == 0) begin : g_acc
      logic [VALUE_WIDTH:0] w_sum;
      assign w_sum         = r_acc[g] + {1'b0, r_value[g]};
      assign w_spike[g]    = w_sum[VALUE_WIDTH];
      assign w_acc_next[g] = {1'b0, w_sum[VALUE_WIDTH-1:0]};
    end else begin : g_lfsr
      localparam int ROT = (3 * g) % 16;
      logic [VALUE_WIDTH-1:0] w_thr;
      // Low bits of {x,x} >> (16-ROT) are x rotated left by ROT.
      assign w_thr         = VALUE_WIDTH'({r_lfsr, r_lfsr} >> (16 - ROT));
      assign w_spike[g]    = (r_value[g] > w_thr);
      assign w_acc_next[g] = r_acc[g];
    end
  end

  always_comb begin
    w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);
    w_step_next = r_step_cnt + CW'(1);
    w_last      = (w_step_next == CW'(NUM_STEPS));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_lfsr        <= SEED;
      r_step_cnt    <= '0;
      r_spike_out   <= '0;
      r_spike_valid <= 1'b0;
      r_neuron_clr  <= 1'b0;
      r_done        <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_value[i] <= '0;
        r_acc[i]   <= '0;
      end
    end else begin
      r_spike_out   <= '0;
      r_spike_valid <= 1'b0;
      r_neuron_clr  <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
              r_value[i] <= in_data[i*VALUE_WIDTH +: VALUE_WIDTH];
              r_acc[i]   <= '0;
            end
            r_step_cnt   <= '0;
            r_lfsr       <= SEED;
            r_state      <= S_RUN;
            r_neuron_clr <= 1'b1;
          end
        end
        S_RUN: begin
          // Abort beats a same-cycle step: that step produces no result.
          if (abort) begin
            r_state <= S_IDLE;
          end else if (step_en) begin
            r_spike_out   <= w_spike;
            r_spike_valid <= 1'b1;
            r_lfsr        <= w_lfsr_next;
            r_step_cnt    <= w_step_next;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
              r_acc[i] <= w_acc_next[i];
            end
            if (w_last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state == S_RUN);
  assign spike_out   = r_spike_out;
  assign spike_valid = r_spike_valid;
  assign neuron_clr  = r_neuron_clr;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder: three instances (MODE0/16 steps, MODE0/8 steps,
// MODE1/256 steps) share stimulus and are checked each cycle against a rate model.
module tb_spike_rate_encoder;

  localparam int          NCH  = 4;
  localparam int          VW   = 8;
  localparam int          NI   = 3;
  localparam int          STEPS [NI] = '{16, 8, 256};
  localparam int          MODES [NI] = '{0, 0, 1};
  localparam logic [15:0] SEED = 16'hACE1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          step_en;
  logic          abort;
  logic [31:0]   in_data;
  logic          in_ready    [NI];
  logic          spike_valid [NI];
  logic          neuron_clr  [NI];
  logic          busy        [NI];
  logic          done        [NI];
  logic          dbg_state   [NI];
  logic [NCH-1:0] spike_out  [NI];

  spike_rate_encoder #(.NUM_CHANNELS(NCH), .VALUE_WIDTH(VW), .NUM_STEPS(16), .MODE(0),
                       .LFSR_SEED(SEED)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
    .step_en(step_en), .abort(abort), .spike_out(spike_out[0]), .spike_valid(spike_valid[0]),
    .neuron_clr(neuron_clr[0]), .busy(busy[0]), .done(done[0]), .o_dbg_state(dbg_state[0]));

  spike_rate_encoder #(.NUM_CHANNELS(NCH), .VALUE_WIDTH(VW), .NUM_STEPS(8), .MODE(0),
                       .LFSR_SEED(SEED)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
    .step_en(step_en), .abort(abort), .spike_out(spike_out[1]), .spike_valid(spike_valid[1]),
    .neuron_clr(neuron_clr[1]), .busy(busy[1]), .done(done[1]), .o_dbg_state(dbg_state[1]));

  spike_rate_encoder #(.NUM_CHANNELS(NCH), .VALUE_WIDTH(VW), .NUM_STEPS(256), .MODE(1),
                       .LFSR_SEED(SEED)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .in_data(in_data),
    .step_en(step_en), .abort(abort), .spike_out(spike_out[2]), .spike_valid(spike_valid[2]),
    .neuron_clr(neuron_clr[2]), .busy(busy[2]), .done(done[2]), .o_dbg_state(dbg_state[2]));

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d t=%0t actual=%0h required=%0h", name, k, $time, act, exp);
    end
  endtask

  task automatic chk_true(input string name, input int k, input int val, input bit ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s inst=%0d t=%0t actual=%0d", name, k, $time, val);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit             m_run  [NI];
  int             m_step [NI];
  int             m_val  [NI][NCH];
  logic [15:0]    m_lfsr [NI];
  logic           e_sv   [NI];
  logic           e_clr  [NI];
  logic           e_done [NI];
  logic [NCH-1:0] exp_q  [NI][$];
  logic [NCH-1:0] m_sp;
  int             m_thr;

  function automatic logic [15:0] rotl16(input logic [15:0] x, input int r);
    logic [15:0] y;
    if (r == 0) y = x;
    else        y = (x << r) | (x >> (16 - r));
    return y;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic void m_reset(input int k);
    m_run[k]  = 1'b0;
    m_step[k] = 0;
    m_lfsr[k] = SEED;
    e_sv[k]   = 1'b0;
    e_clr[k]  = 1'b0;
    e_done[k] = 1'b0;
    exp_q[k].delete();
    for (int c = 0; c < NCH; c++) m_val[k][c] = 0;
  endfunction

  initial for (int k = 0; k < NI; k++) m_reset(k);

  // A channel of value v fires at step n exactly when floor(n*v/256) increases (MODE 0),
  // or when v exceeds the low byte of the rotated LFSR (MODE 1).
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst) begin
        m_reset(k);
      end else begin
        e_sv[k] = 1'b0; e_clr[k] = 1'b0; e_done[k] = 1'b0;
        if (!m_run[k]) begin
          if (in_valid) begin
            for (int c = 0; c < NCH; c++) m_val[k][c] = int'(in_data[c*VW +: VW]);
            m_step[k] = 0;
            m_lfsr[k] = SEED;
            m_run[k]  = 1'b1;
            e_clr[k]  = 1'b1;
          end
        end else if (abort) begin
          m_run[k] = 1'b0;
        end else if (step_en) begin
          m_step[k]++;
          m_sp = '0;
          for (int c = 0; c < NCH; c++) begin
            if (MODES[k] == 0) begin
              m_sp[c] = ((m_step[k] * m_val[k][c]) / 256) != (((m_step[k] - 1) * m_val[k][c]) / 256);
            end else begin
              m_thr   = int'(rotl16(m_lfsr[k], (3 * c) % 16) & 16'h00FF);
              m_sp[c] = (m_val[k][c] > m_thr);
            end
          end
          m_lfsr[k] = lfsr_next(m_lfsr[k]);
          exp_q[k].push_back(m_sp);
          e_sv[k] = 1'b1;
          if (m_step[k] == STEPS[k]) begin
            m_run[k]  = 1'b0;
            e_done[k] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard / stats ----------------
  int          sv_cnt   [NI];
  int          done_cnt [NI];
  int          clr_cnt  [NI];
  int          spk_cnt  [NI][NCH];
  logic [15:0] smask    [NI][NCH];
  logic [NCH-1:0] exp_sp;

  function automatic void clear_stats();
    for (int k = 0; k < NI; k++) begin
      sv_cnt[k] = 0; done_cnt[k] = 0; clr_cnt[k] = 0;
      for (int c = 0; c < NCH; c++) begin
        spk_cnt[k][c] = 0;
        smask[k][c]   = '0;
      end
    end
  endfunction

  initial clear_stats();

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < NI; k++) begin
        chk("in_ready", k, 32'(in_ready[k]), 32'(!m_run[k]));
        chk("busy", k, 32'(busy[k]), 32'(m_run[k]));
        chk("dbg_state", k, 32'(dbg_state[k]), 32'(m_run[k]));
        chk("spike_valid", k, 32'(spike_valid[k]), 32'(e_sv[k]));
        chk("neuron_clr", k, 32'(neuron_clr[k]), 32'(e_clr[k]));
        chk("done", k, 32'(done[k]), 32'(e_done[k]));
        if (e_sv[k] && exp_q[k].size() > 0) begin
          exp_sp = exp_q[k].pop_front();
          chk("spike_out", k, 32'(spike_out[k]), 32'(exp_sp));
        end else begin
          chk("spike_out_idle", k, 32'(spike_out[k]), 32'h0);
        end
        if (spike_valid[k]) begin
          for (int c = 0; c < NCH; c++) begin
            if (spike_out[k][c]) begin
              spk_cnt[k][c]++;
              if (sv_cnt[k] < 16) smask[k][c][sv_cnt[k]] = 1'b1;
            end
          end
          sv_cnt[k]++;
        end
        if (done[k])       done_cnt[k]++;
        if (neuron_clr[k]) clr_cnt[k]++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic bit all_idle();
    return in_ready[0] && in_ready[1] && in_ready[2];
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", -1, 32'(all_idle()), 32'h1);
  endtask

  task automatic load(input logic [31:0] d);
    wait_idle(600);
    @(negedge clk);
    clear_stats();
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < NI; k++) begin
      chk("clr_after_accept", k, 32'(neuron_clr[k]), 32'h1);
      chk("busy_after_accept", k, 32'(busy[k]), 32'h1);
    end
  endtask

  task automatic run_steps(input int n);
    repeat (n) begin
      step_en = 1'b1;
      @(negedge clk);
    end
    step_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic kill();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b0; in_valid = 1'b0; step_en = 1'b0; abort = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_in_ready", k, 32'(in_ready[k]), 32'h1);
      chk("rst_busy", k, 32'(busy[k]), 32'h0);
      chk("rst_spike_valid", k, 32'(spike_valid[k]), 32'h0);
      chk("rst_spike_out", k, 32'(spike_out[k]), 32'h0);
      chk("rst_neuron_clr", k, 32'(neuron_clr[k]), 32'h0);
      chk("rst_done", k, 32'(done[k]), 32'h0);
    end
    rst = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    // All channels 128 with step_en held high, including while idle.
    step_en = 1'b1;
    load(32'h80808080);
    run_steps(16);
    for (int c = 0; c < NCH; c++) begin
      chk("a_mask8", c, 32'(smask[1][c]), 32'h00AA);
      chk("a_mask16", c, 32'(smask[0][c]), 32'hAAAA);
    end
    chk("a_done8", 1, done_cnt[1], 1);
    chk("a_sv8", 1, sv_cnt[1], 8);
    chk("a_done16", 0, done_cnt[0], 1);
    kill();

    // Mixed values {0,64,255,1}.
    load(32'h01FF4000);
    run_steps(16);
    chk("b_cnt_ch0", 0, spk_cnt[0][0], 0);
    chk("b_cnt_ch1", 0, spk_cnt[0][1], 4);
    chk("b_cnt_ch2", 0, spk_cnt[0][2], 15);
    chk("b_cnt_ch3", 0, spk_cnt[0][3], 0);
    chk("b_mask_ch1", 0, 32'(smask[0][1]), 32'h8888);
    chk("b_cnt8_ch2", 1, spk_cnt[1][2], 7);
    kill();

    // Alternating step_en: spikes follow step index, not cycle count.
    load(32'h80808080);
    for (int i = 0; i < 32; i++) begin
      step_en = (i % 2 == 0);
      @(negedge clk);
    end
    step_en = 1'b0;
    @(negedge clk);
    chk("c_mask16", 0, 32'(smask[0][0]), 32'hAAAA);
    chk("c_sv16", 0, sv_cnt[0], 16);
    chk("c_mask8", 1, 32'(smask[1][0]), 32'h00AA);
    kill();

    // Abort after three steps, with a step requested in the abort cycle.
    load(32'h80808080);
    step_en = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    step_en = 1'b0;
    abort = 1'b0;
    chk("d_ready_after_abort", 0, 32'(in_ready[0]), 32'h1);
    chk("d_sv_after_abort", 0, 32'(spike_valid[0]), 32'h0);
    repeat (3) @(negedge clk);
    chk("d_sv_cnt", 0, sv_cnt[0], 3);
    chk("d_done_cnt", 0, done_cnt[0], 0);
    chk("d_clr_cnt", 0, clr_cnt[0], 1);
    load(32'h80808080);
    run_steps(16);
    chk("d_mask_restart", 0, 32'(smask[0][0]), 32'hAAAA);
    kill();

    // MODE1: channel 0 = 0, channel 1 = 255, run twice from the same seed.
    for (int r = 0; r < 2; r++) begin
      load(32'h1080FF00);
      run_steps(256);
      chk("e_m1_ch0", 2, spk_cnt[2][0], 0);
      chk_true("e_m1_ch1_ge250", 2, spk_cnt[2][1], spk_cnt[2][1] >= 250);
      chk("e_m1_done", 2, done_cnt[2], 1);
    end

    // Randomised traffic.
    repeat (600) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = $urandom();
      if ($urandom_range(0, 3) == 0) in_data[7:0] = 8'h00;
      if ($urandom_range(0, 3) == 0) in_data[15:8] = 8'hFF;
      step_en  = ($urandom_range(0, 2) != 0);
      abort    = ($urandom_range(0, 31) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0; step_en = 1'b0; abort = 1'b0;
    kill();

    // Asynchronous reset in the middle of a presentation.
    load(32'h80C01040);
    step_en = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    step_en = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("g_rst_in_ready", k, 32'(in_ready[k]), 32'h1);
      chk("g_rst_busy", k, 32'(busy[k]), 32'h0);
      chk("g_rst_sv", k, 32'(spike_valid[k]), 32'h0);
      chk("g_rst_spike", k, 32'(spike_out[k]), 32'h0);
    end
    repeat (2) @(negedge clk);
    #3;
    rst = 1'b1;
    @(negedge clk);
    load(32'h80808080);
    run_steps(16);
    chk("g_mask_after_rst", 0, 32'(smask[0][0]), 32'hAAAA);
    kill();

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
